// File: rtl/spike_enc_pkg.sv
// Shared types and arithmetic helper for the delta-modulation spike encoder.
package spike_enc_pkg;

  localparam int DEF_DATA_W = 16;
  // Internal width of the add/sub helper; any DATA_W up to this is supported.
  localparam int MAX_W      = 64;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    SPK_NONE = 2'd0,
    SPK_UP   = 2'd1,
    SPK_DN   = 2'd2
  } spk_dir_e;

  // Baseline plus or minus a zero-extended delta, one bit wider than the
  // operands so the result is always exact.
  function automatic logic signed [MAX_W:0] base_step(
    input logic signed [MAX_W-1:0] base,
    input logic        [MAX_W-1:0] delta,
    input logic                    sub
  );
    logic signed [MAX_W:0] b;
    logic signed [MAX_W:0] d;
    b = {base[MAX_W-1], base};
    d = {1'b0, delta};
    if (sub) begin
      base_step = b - d;
    end else begin
      base_step = b + d;
    end
  endfunction

endpackage

// File: rtl/spike_enc_chan.sv
// One encoder channel: baseline, init flag, refractory counter and the
// per-sample spike decision. Direction is combinational; the top registers it.
module spike_enc_chan
  import spike_enc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REFRACT = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     strobe_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic        [DATA_W-2:0] delta_i,
  output spk_dir_e                 dir_o
);

  localparam int CNT_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [CNT_W-1:0] REFRACT_C = CNT_W'(REFRACT);

  typedef logic signed [DATA_W:0] wide_t;

  logic signed [DATA_W-1:0] base_q, base_d;
  logic                     init_q, init_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  spk_dir_e                 dir_s;

  wide_t samp_s;
  wide_t up_s;
  wide_t dn_s;

  // Thresholds one delta either side of the baseline, in DATA_W+1 bits.
  always_comb begin
    samp_s = wide_t'(sample_i);
    up_s   = wide_t'(base_step(MAX_W'(base_q), MAX_W'(delta_i), 1'b0));
    dn_s   = wide_t'(base_step(MAX_W'(base_q), MAX_W'(delta_i), 1'b1));
  end

  // Priority decision: disable, init, refractory, zero delta, up, down, hold.
  always_comb begin
    base_d = base_q;
    init_d = init_q;
    cnt_d  = cnt_q;
    dir_s  = SPK_NONE;
    if (!strobe_i) begin
      dir_s = SPK_NONE;
    end else if (!en_i) begin
      dir_s = SPK_NONE;
    end else if (!init_q) begin
      base_d = sample_i;
      init_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (delta_i == '0) begin
      dir_s = SPK_NONE;
    end else if (samp_s >= up_s) begin
      base_d = up_s[DATA_W-1:0];
      cnt_d  = REFRACT_C;
      dir_s  = SPK_UP;
    end else if (samp_s <= dn_s) begin
      base_d = dn_s[DATA_W-1:0];
      cnt_d  = REFRACT_C;
      dir_s  = SPK_DN;
    end else begin
      dir_s = SPK_NONE;
    end
  end

  // Channel state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q <= '0;
      init_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      base_q <= base_d;
      init_q <= init_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dir_o = dir_s;

endmodule

// File: rtl/spike_encoder_mc.sv
// Multi-channel delta-modulation spike encoder: N_CHAN parallel channels on
// a shared sample strobe, registered spike vectors one cycle later.
module spike_encoder_mc
  import spike_enc_pkg::*;
#(
  parameter int N_CHAN  = 4,
  parameter int DATA_W  = 16,
  parameter int REFRACT = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_valid_i,
  input  logic [N_CHAN*DATA_W-1:0] sample_i,
  input  logic [DATA_W-2:0]        delta_i,
  input  logic [N_CHAN-1:0]        chan_en_i,
  output logic                     spike_valid_o,
  output logic [N_CHAN-1:0]        spike_up_o,
  output logic [N_CHAN-1:0]        spike_dn_o
);

  logic [N_CHAN-1:0] up_d;
  logic [N_CHAN-1:0] dn_d;
  logic              valid_q;
  logic [N_CHAN-1:0] up_q;
  logic [N_CHAN-1:0] dn_q;

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    spk_dir_e dir_s;

    spike_enc_chan #(
      .DATA_W  (DATA_W),
      .REFRACT (REFRACT)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .strobe_i (sample_valid_i),
      .en_i     (chan_en_i[c]),
      .sample_i ($signed(sample_i[c*DATA_W +: DATA_W])),
      .delta_i  (delta_i),
      .dir_o    (dir_s)
    );

    assign up_d[c] = (dir_s == SPK_UP);
    assign dn_d[c] = (dir_s == SPK_DN);
  end

  // Output register: vectors only carry data in the cycle valid is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      up_q    <= '0;
      dn_q    <= '0;
    end else if (sample_valid_i) begin
      valid_q <= 1'b1;
      up_q    <= up_d;
      dn_q    <= dn_d;
    end else begin
      valid_q <= 1'b0;
      up_q    <= '0;
      dn_q    <= '0;
    end
  end

  assign spike_valid_o = valid_q;
  assign spike_up_o    = up_q;
  assign spike_dn_o    = dn_q;

endmodule
